exe_seq: RTL and testbench

Execute-stage sequencer for the RV32I pipeline. Owns the ID->EX handshake and decides when the EX pipeline register captures. Schedules multi-cycle operations on the shared iterative mul/div unit and holds results under MEM back-pressure. Detects load-use hazards and drives the front-end flush when a resolved jump retires from EX.

---
 rtl/exe_seq.sv | 167 ++++++++++++++++
 tb/tb_exe_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/exe_seq.sv
`default_nettype none
// ============================================================================
//  Module      : exe_seq
//  Description : Execute-stage sequencer for the RV32I pipeline. Owns the
//                ID->EX handshake, schedules the shared iterative mul/div
//                unit, holds results under MEM back-pressure, inserts the
//                load-use bubble and raises the front-end flush when a taken
//                jump retires from EX.
//  Options     : EXE_STALL_CNT_EN - adds the 32-bit o_stall_cnt output.
//  Revision    : 1.0 - initial release
// ============================================================================
module exe_seq #(
    parameter int FLUSH_DRAIN = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_id_valid,
    output logic       o_id_ready,
    input  logic       i_id_multi,
    input  logic       i_id_is_load,
    input  logic [4:0] i_id_rd,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_use_rs1,
    input  logic       i_id_use_rs2,
    output logic       o_ex_load,
    output logic       o_mc_start,
    input  logic       i_mc_done,
    input  logic       i_jump_taken,
    output logic       o_ex_valid,
    input  logic       i_mem_ready,
    output logic       o_flush
`ifdef EXE_STALL_CNT_EN
    ,
    output logic [31:0] o_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_MC    = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [2:0] C_DRAIN_INIT = 3'(FLUSH_DRAIN);

    state_t     r_state;
    logic [2:0] r_cnt;
    logic       r_is_load;
    logic [4:0] r_rd;
    logic       r_mc_first;

    logic w_hazard;
    logic w_retire;
    logic w_id_ready;
    logic w_accept;

    // A load still sitting in EX whose destination is read by the next
    // instruction costs one bubble; MEM->EX forwarding covers it afterwards.
    assign w_hazard = (r_state == S_FULL) & r_is_load & (r_rd != 5'd0) & i_id_valid &
                      ((i_id_use_rs1 & (i_id_rs1 == r_rd)) |
                       (i_id_use_rs2 & (i_id_rs2 == r_rd)));

    assign w_retire = (r_state == S_FULL) & i_mem_ready;

    // Decode-side ready; gated by reset so every output reads 0 while held.
    always_comb begin
        w_id_ready = 1'b0;
        case (r_state)
            S_EMPTY: w_id_ready = 1'b1;
            S_FULL:  w_id_ready = w_retire & ~i_jump_taken & ~w_hazard;
            S_DRAIN: w_id_ready = 1'b1;
            default: w_id_ready = 1'b0;
        endcase
        w_id_ready = w_id_ready & i_rst;
    end

    // Instructions handshaken during DRAIN are swallowed, never captured.
    assign w_accept   = i_id_valid & w_id_ready & (r_state != S_DRAIN);

    assign o_id_ready = w_id_ready;
    assign o_ex_load  = w_accept;
    assign o_ex_valid = (r_state == S_FULL);
    assign o_mc_start = (r_state == S_MC) & r_mc_first;
    assign o_flush    = w_retire & i_jump_taken & i_rst;

    // Sequencer state, captured-instruction attributes and drain counter.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= S_EMPTY;
            r_cnt      <= 3'd0;
            r_is_load  <= 1'b0;
            r_rd       <= 5'd0;
            r_mc_first <= 1'b0;
        end else begin
            r_mc_first <= 1'b0;
            if (w_accept) begin
                r_is_load <= i_id_is_load;
                r_rd      <= i_id_rd;
            end
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        if (i_id_multi) begin
                            r_state    <= S_MC;
                            r_mc_first <= 1'b1;
                        end else begin
                            r_state <= S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (w_retire) begin
                        if (i_jump_taken) begin
                            if (FLUSH_DRAIN == 0) begin
                                r_state <= S_EMPTY;
                            end else begin
                                r_state <= S_DRAIN;
                                r_cnt   <= C_DRAIN_INIT;
                            end
                        end else if (w_accept) begin
                            // Back-to-back: the retiring slot is refilled now.
                            if (i_id_multi) begin
                                r_state    <= S_MC;
                                r_mc_first <= 1'b1;
                            end else begin
                                r_state <= S_FULL;
                            end
                        end else begin
                            r_state <= S_EMPTY;
                        end
                    end
                end
                S_MC: begin
                    if (i_mc_done) begin
                        r_state <= S_FULL;
                    end
                end
                S_DRAIN: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt <= 3'd1) begin
                        r_state <= S_EMPTY;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

`ifdef EXE_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Counts cycles where decode offers work that EX cannot take.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_stall_cnt <= 32'd0;
        end else if (i_id_valid & ~w_id_ready & (r_state != S_DRAIN)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_exe_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exe_seq
//  Description : Self-checking bench for exe_seq (FLUSH_DRAIN = 2). Each
//                cycle's expected control vector
//                {id_ready, ex_load, mc_start, ex_valid, flush} is queued
//                when stimulus is driven and popped when outputs are sampled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exe_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_ready, id_multi, id_is_load;
    logic [4:0] id_rd, id_rs1, id_rs2;
    logic       use_rs1, use_rs2;
    logic       ex_load, mc_start, mc_done, jump_taken, ex_valid, mem_ready, flush;
`ifdef EXE_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [4:0] sb_q[$];

    always #5 clk = ~clk;

    exe_seq #(.FLUSH_DRAIN(2)) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_id_valid   (id_valid),
        .o_id_ready   (id_ready),
        .i_id_multi   (id_multi),
        .i_id_is_load (id_is_load),
        .i_id_rd      (id_rd),
        .i_id_rs1     (id_rs1),
        .i_id_rs2     (id_rs2),
        .i_id_use_rs1 (use_rs1),
        .i_id_use_rs2 (use_rs2),
        .o_ex_load    (ex_load),
        .o_mc_start   (mc_start),
        .i_mc_done    (mc_done),
        .i_jump_taken (jump_taken),
        .o_ex_valid   (ex_valid),
        .i_mem_ready  (mem_ready),
        .o_flush      (flush)
`ifdef EXE_STALL_CNT_EN
        ,
        .o_stall_cnt  (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at posedge+1, queue expectation, sample at negedge.
    task automatic cyc(input string tag, input logic v, input logic m, input logic ld,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic done, input logic jmp,
                       input logic mrdy, input logic [4:0] exp);
        logic [4:0] e;
        id_valid = v;  id_multi = m;  id_is_load = ld;
        id_rd = rd;    id_rs1 = rs1;  id_rs2 = rs2;
        use_rs1 = u1;  use_rs2 = u2;
        mc_done = done; jump_taken = jmp; mem_ready = mrdy;
        sb_q.push_back(exp);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk(tag, {27'd0, id_ready, ex_load, mc_start, ex_valid, flush}, {27'd0, e});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        id_valid = 1'b1; id_multi = 1'b0; id_is_load = 1'b0;
        id_rd = 5'd1; id_rs1 = 5'd0; id_rs2 = 5'd0;
        use_rs1 = 1'b0; use_rs2 = 1'b0;
        mc_done = 1'b1; jump_taken = 1'b1; mem_ready = 1'b1;
        #3;
        chk("reset_outs", {27'd0, id_ready, ex_load, mc_start, ex_valid, flush}, 32'd0);
`ifdef EXE_STALL_CNT_EN
        chk("reset_stall", stall_cnt, 32'd0);
`endif
        @(posedge clk); @(posedge clk); #1;
        chk("reset_hold", {27'd0, id_ready, ex_load, mc_start, ex_valid, flush}, 32'd0);
        rst = 1'b1;

        // Four back-to-back single-cycle ops
        //   tag       v  m  ld rd     rs1    rs2    u1 u2 dn jp mr exp
        cyc("b2b_1",   1, 0, 0, 5'd1, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b11000);
        cyc("b2b_2",   1, 0, 0, 5'd2, 5'd1, 5'd0, 1, 0, 0, 0, 1, 5'b11010);
        cyc("b2b_3",   1, 0, 0, 5'd3, 5'd2, 5'd0, 1, 0, 0, 0, 1, 5'b11010);
        cyc("b2b_4",   1, 0, 0, 5'd4, 5'd3, 5'd0, 1, 0, 0, 0, 1, 5'b11010);
        cyc("b2b_5",   0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b10010);
        cyc("b2b_idle",0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b10000);

        // Load-use on rs1 (x5): exactly one bubble
        cyc("lu_ld",   1, 0, 1, 5'd5, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b11000);
        cyc("lu_stall",1, 0, 0, 5'd6, 5'd5, 5'd0, 1, 0, 0, 0, 1, 5'b00010);
        cyc("lu_acc",  1, 0, 0, 5'd6, 5'd5, 5'd0, 1, 0, 0, 0, 1, 5'b11000);
        cyc("lu_ret",  0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b10010);
        // Load to x0: no stall
        cyc("x0_ld",   1, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b11000);
        cyc("x0_use",  1, 0, 0, 5'd6, 5'd0, 5'd0, 1, 0, 0, 0, 1, 5'b11010);
        cyc("x0_ret",  0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b10010);
        // Load-use via rs2 stalls; matching rs1 that is not read does not
        cyc("rs2_ld",  1, 0, 1, 5'd7, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b11000);
        cyc("rs2_stl", 1, 0, 0, 5'd8, 5'd1, 5'd7, 1, 1, 0, 0, 1, 5'b00010);
        cyc("rs2_acc", 1, 0, 0, 5'd8, 5'd1, 5'd7, 1, 1, 0, 0, 1, 5'b11000);
        cyc("rs2_ret", 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b10010);
        cyc("nu_ld",   1, 0, 1, 5'd7, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b11000);
        cyc("nu_op",   1, 0, 0, 5'd9, 5'd7, 5'd3, 0, 1, 0, 0, 1, 5'b11010);
        cyc("nu_ret",  0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b10010);

        // Multi-cycle op, done 6 cycles after start
        cyc("mc_acc",  1, 1, 0, 5'd10, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b11000);
        cyc("mc_start",1, 0, 0, 5'd11, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b00100);
        for (int i = 0; i < 5; i++)
            cyc("mc_wait",1, 0, 0, 5'd11, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b00000);
        cyc("mc_done", 1, 0, 0, 5'd11, 5'd0, 5'd0, 0, 0, 1, 0, 1, 5'b00000);
        cyc("mc_full", 1, 0, 0, 5'd11, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b11010);
        cyc("mc_ret",  0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b10010);
        // Done in the first MC cycle; stray done outside MC ignored
        cyc("mc1_acc", 1, 1, 0, 5'd12, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b11000);
        cyc("mc1_dn",  0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1, 5'b00100);
        cyc("mc1_full",0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b10010);
        cyc("done_ign",0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1, 5'b10000);
        cyc("done_ig2",0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b10000);

        // Taken jump retiring from FULL, FLUSH_DRAIN = 2
        cyc("j_acc",   1, 0, 0, 5'd13, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b11000);
        cyc("j_flush", 1, 0, 0, 5'd14, 5'd0, 5'd0, 0, 0, 0, 1, 1, 5'b00011);
        cyc("j_drain1",1, 0, 0, 5'd14, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b10000);
        cyc("j_drain2",1, 0, 0, 5'd15, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b10000);
        cyc("j_empty", 1, 0, 0, 5'd16, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b11000);
        cyc("j_ret",   0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b10010);
        cyc("j_ignore",0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 5'b10000);

        // MEM back-pressure for 3 cycles, then retire + accept together
        cyc("bp_acc",  1, 0, 0, 5'd17, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b11000);
        for (int i = 0; i < 3; i++)
            cyc("bp_hold",1, 0, 0, 5'd18, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'b00010);
        cyc("bp_rel",  1, 0, 0, 5'd18, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b11010);
        cyc("bp_ret",  0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b10010);

`ifdef EXE_STALL_CNT_EN
        // lu_stall + rs2_stl + 7 MC cycles + j_flush + 3 back-pressure
        chk("stall_cnt", stall_cnt, 32'd13);
`endif

        // Reset asserted mid-MC
        cyc("rm_acc",  1, 1, 0, 5'd19, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b11000);
        cyc("rm_start",0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b00100);
        id_valid = 1'b1; jump_taken = 1'b1; mem_ready = 1'b1; mc_done = 1'b0;
        rst = 1'b0;
        #1;
        chk("rm_outs", {27'd0, id_ready, ex_load, mc_start, ex_valid, flush}, 32'd0);
`ifdef EXE_STALL_CNT_EN
        chk("rm_stall", stall_cnt, 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b1;
        cyc("rm_empty",0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b10000);
        cyc("rm_nostr",0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b10000);
        cyc("rm_acc2", 1, 0, 0, 5'd20, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b11000);
        cyc("rm_ret",  0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 5'b10010);

        if (sb_q.size() != 0) chk("sb_left", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
